trace_trig_shaper: RTL and testbench
====================================

Name: trace_trig_shaper

Overview:
Downstream stage of the trace pattern matcher, in the TRACECLK domain. Consumes the per-cycle match pulse and matching-rule bits (matcher in pulse mode) and produces the final shaped trigger for the capture hardware. Supports rule qualification, Nth-match counting, programmable delay, pulse width and holdoff, plus one-shot or re-arming operation.

Parameters:
pMATCH_RULES, 8, number of match rules and width of rule bit vectors
pCOUNT_WIDTH, 8, width of match-count target and match-seen counter
pTIME_WIDTH, 16, width of delay, pulse-width and holdoff counters

Ports:
TRACECLK  input  1  trace clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
I_match  input  1  one-cycle match pulse from matcher
I_matching_pattern  input  pMATCH_RULES  rule bits that matched, valid when I_match=1
I_rule_select  input  pMATCH_RULES  rules that qualify for triggering
I_arm  input  1  one-cycle arm request (already synchronized to TRACECLK)
I_abort  input  1  return to IDLE immediately
I_oneshot  input  1  1: IDLE after trigger; 0: re-arm after holdoff
I_match_target  input  pCOUNT_WIDTH  qualifying matches needed to trigger (0 treated as 1)
I_delay  input  pTIME_WIDTH  cycles from trigger decision to pulse start
I_pulse_width  input  pTIME_WIDTH  trigger high time in cycles (0 treated as 1)
I_holdoff  input  pTIME_WIDTH  dead cycles after pulse before re-arm
O_trig_out  output  1  shaped trigger, registered
O_armed  output  1  state==ARMED
O_busy  output  1  state is DELAY, PULSE or HOLDOFF
O_state  output  3  current state encoding
O_match_seen  output  pCOUNT_WIDTH  qualifying matches since last arm/re-arm
O_trig_count  output  8  triggers issued since reset

Behaviour:
- Reset (async): state IDLE, all outputs 0, all internal counters 0.
- Qualifying match q = I_match && |(I_matching_pattern & I_rule_select).
- States: IDLE=0, ARMED=1, DELAY=2, PULSE=3, HOLDOFF=4; other encodings never occur (recover to IDLE).
- Priority each edge: I_abort > state logic. Abort: any state -> IDLE, O_trig_out 0, O_match_seen 0, timers 0; O_trig_count unchanged. I_arm and I_abort in same cycle: abort wins.
- IDLE: I_arm -> ARMED, O_match_seen cleared. q in IDLE ignored, including in the I_arm cycle.
- ARMED: on q, O_match_seen increments (saturating at all-ones). When the incremented value >= effective target, latch I_delay, I_pulse_width, I_holdoff; go DELAY if delay>0, else PULSE.
- Timing: final qualifying match present in cycle c -> O_trig_out high exactly in cycles c+1+D through c+D+W (D=latched delay, W=latched effective width).
- DELAY: counts D cycles, then PULSE. PULSE: O_trig_out=1 for W cycles, then HOLDOFF if H>0, else exit.
- HOLDOFF: counts H cycles, O_trig_out=0, then exit.
- Exit: I_oneshot=1 -> IDLE; else ARMED with O_match_seen cleared. I_oneshot sampled at exit. First countable q is in the first ARMED cycle.
- q during DELAY/PULSE/HOLDOFF ignored, not counted. I_arm outside IDLE ignored.
- Config inputs changing mid-operation have no effect until the next latch point. I_match_target is compared live in ARMED.
- O_trig_count increments by 1 per PULSE entry and wraps 255->0.
- Consecutive triggers with H=0, D=0, continuous mode: gap of at least one low cycle guaranteed (exit to ARMED precedes next pulse).

Test Plan:
- Reset mid-PULSE (async assert between edges): O_trig_out, O_state, O_match_seen drop to 0 immediately. No clock required.
- Arm, target=1, D=0, W=1, select=0x01, one match with pattern 0x01 in cycle c: O_trig_out high in cycle c+1 only. Oneshot=1 -> O_state=0, O_trig_count=1.
- Target=3, D=5, W=4, H=10, oneshot=0, matches at c, c+2, c+4: O_match_seen 1,2,3. Trigger high cycles c+10..c+13. Matches in c+5..c+23 not counted. O_armed=1 at c+24, O_match_seen=0.
- Select=0x04, matches with pattern 0x03: no count, no trigger. Pattern 0x84: counted.
- Abort during DELAY with I_arm same cycle: next state IDLE, no pulse, O_trig_count unchanged. Arm while ARMED: no effect on O_match_seen.
- W=0, target=0: behaves as W=1, target=1. Continuous mode, D=H=0, matches every cycle: pulses every 2 cycles. O_trig_count wraps 255->0 after 256 triggers.

Source files
------------

// File: rtl/trace_trig_shaper_if.sv
// Match-side and trigger-side signal bundle for the trace trigger shaper.
// The master drives the matcher/config inputs; the slave is the shaper.
interface trace_trig_shaper_if #(
  parameter int pMATCH_RULES = 8,
  parameter int pCOUNT_WIDTH = 8,
  parameter int pTIME_WIDTH  = 16
);
  logic                    I_match;
  logic [pMATCH_RULES-1:0] I_matching_pattern;
  logic [pMATCH_RULES-1:0] I_rule_select;
  logic                    I_arm;
  logic                    I_abort;
  logic                    I_oneshot;
  logic [pCOUNT_WIDTH-1:0] I_match_target;
  logic [pTIME_WIDTH-1:0]  I_delay;
  logic [pTIME_WIDTH-1:0]  I_pulse_width;
  logic [pTIME_WIDTH-1:0]  I_holdoff;

  logic                    O_trig_out;
  logic                    O_armed;
  logic                    O_busy;
  logic [2:0]              O_state;
  logic [pCOUNT_WIDTH-1:0] O_match_seen;
  logic [7:0]              O_trig_count;

  modport master (
    output I_match, I_matching_pattern, I_rule_select, I_arm, I_abort,
           I_oneshot, I_match_target, I_delay, I_pulse_width, I_holdoff,
    input  O_trig_out, O_armed, O_busy, O_state, O_match_seen, O_trig_count
  );

  modport slave (
    input  I_match, I_matching_pattern, I_rule_select, I_arm, I_abort,
           I_oneshot, I_match_target, I_delay, I_pulse_width, I_holdoff,
    output O_trig_out, O_armed, O_busy, O_state, O_match_seen, O_trig_count
  );
endinterface

// File: rtl/trace_trig_shaper.sv
// Shapes per-cycle trace match pulses into the final capture trigger:
// rule qualification, Nth-match count, delay, pulse width, holdoff, one-shot/re-arm.
module trace_trig_shaper #(
  parameter int pMATCH_RULES = 8,
  parameter int pCOUNT_WIDTH = 8,
  parameter int pTIME_WIDTH  = 16
) (
  input  logic                TRACECLK,
  input  logic                reset,
  trace_trig_shaper_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_PULSE   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  localparam logic [pTIME_WIDTH-1:0]  T_ONE = pTIME_WIDTH'(1);
  localparam logic [pCOUNT_WIDTH-1:0] C_ONE = pCOUNT_WIDTH'(1);

  state_t                  state, state_nxt, exit_state;
  logic                    q, hit, timer_done;
  logic [pCOUNT_WIDTH-1:0] seen_r, seen_inc, target_eff;
  logic [pTIME_WIDTH-1:0]  timer_r, width_r, holdoff_r, width_eff;
  logic                    trig_r;
  logic [7:0]              trig_cnt_r;

  assign q          = bus.I_match && |(bus.I_matching_pattern & bus.I_rule_select);
  assign seen_inc   = (&seen_r) ? seen_r : seen_r + C_ONE;
  assign target_eff = (bus.I_match_target == '0) ? C_ONE : bus.I_match_target;
  assign width_eff  = (bus.I_pulse_width == '0) ? T_ONE : bus.I_pulse_width;
  assign hit        = (state == S_ARMED) && q && (seen_inc >= target_eff);
  assign timer_done = (timer_r == '0);
  assign exit_state = bus.I_oneshot ? S_IDLE : S_ARMED;

  // State register
  always_ff @(posedge TRACECLK or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_nxt = state;
    if (bus.I_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (bus.I_arm) state_nxt = S_ARMED;
        S_ARMED:   if (hit) state_nxt = (bus.I_delay != '0) ? S_DELAY : S_PULSE;
        S_DELAY:   if (timer_done) state_nxt = S_PULSE;
        S_PULSE:   if (timer_done) state_nxt = (holdoff_r != '0) ? S_HOLDOFF : exit_state;
        S_HOLDOFF: if (timer_done) state_nxt = exit_state;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: timer is a down-counter loaded with (period - 1) on each phase entry
  always_ff @(posedge TRACECLK or posedge reset) begin
    if (reset) begin
      trig_r     <= 1'b0;
      trig_cnt_r <= '0;
      seen_r     <= '0;
      timer_r    <= '0;
      width_r    <= '0;
      holdoff_r  <= '0;
    end else if (bus.I_abort) begin
      trig_r    <= 1'b0;
      seen_r    <= '0;
      timer_r   <= '0;
      width_r   <= '0;
      holdoff_r <= '0;
    end else begin
      trig_r <= (state_nxt == S_PULSE);
      if (state != S_PULSE && state_nxt == S_PULSE)
        trig_cnt_r <= trig_cnt_r + 8'd1;

      if (state != S_ARMED && state_nxt == S_ARMED)
        seen_r <= '0;
      else if (state == S_ARMED && q)
        seen_r <= seen_inc;

      case (state)
        S_ARMED: begin
          if (hit) begin
            width_r   <= width_eff;
            holdoff_r <= bus.I_holdoff;
            timer_r   <= (bus.I_delay != '0) ? bus.I_delay - T_ONE : width_eff - T_ONE;
          end
        end
        S_DELAY:   timer_r <= timer_done ? width_r - T_ONE : timer_r - T_ONE;
        S_PULSE: begin
          if (!timer_done)           timer_r <= timer_r - T_ONE;
          else if (holdoff_r != '0)  timer_r <= holdoff_r - T_ONE;
          else                       timer_r <= '0;
        end
        S_HOLDOFF: if (!timer_done) timer_r <= timer_r - T_ONE;
        default:   timer_r <= '0;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.O_trig_out   = trig_r;
    bus.O_armed      = (state == S_ARMED);
    bus.O_busy       = (state == S_DELAY) || (state == S_PULSE) || (state == S_HOLDOFF);
    bus.O_state      = state;
    bus.O_match_seen = seen_r;
    bus.O_trig_count = trig_cnt_r;
  end

endmodule

// File: tb/tb_trace_trig_shaper.sv
// Directed, table-driven bench for trace_trig_shaper with hand-computed expectations.
module tb_trace_trig_shaper;

  logic TRACECLK = 1'b0;
  logic reset    = 1'b1;

  trace_trig_shaper_if #(.pMATCH_RULES(8), .pCOUNT_WIDTH(8), .pTIME_WIDTH(16)) bus ();

  trace_trig_shaper #(.pMATCH_RULES(8), .pCOUNT_WIDTH(8), .pTIME_WIDTH(16)) dut (
    .TRACECLK (TRACECLK),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 TRACECLK = ~TRACECLK;

  typedef struct {
    logic        arm, abort, match;
    logic [7:0]  pat, sel, target;
    logic [15:0] dly, wid, hld;
    logic        oneshot;
    logic        trig;
    logic [2:0]  st;
    logic [7:0]  seen, cnt;
  } vec_t;

  vec_t        tbl[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [7:0]  c_sel, c_target;
  logic [15:0] c_dly, c_wid, c_hld;
  logic        c_oneshot;

  task automatic add(input logic arm, input logic abort, input logic match,
                     input logic [7:0] pat, input logic trig, input logic [2:0] st,
                     input logic [7:0] seen, input logic [7:0] cnt);
    vec_t v;
    v.arm = arm; v.abort = abort; v.match = match; v.pat = pat;
    v.sel = c_sel; v.target = c_target; v.dly = c_dly; v.wid = c_wid; v.hld = c_hld;
    v.oneshot = c_oneshot; v.trig = trig; v.st = st; v.seen = seen; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int unsigned idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int unsigned idx, input logic trig, input logic [2:0] st,
                               input logic [7:0] seen, input logic [7:0] cnt);
    n_vec++;
    chk("trig_out",   idx, 32'(bus.O_trig_out),   32'(trig));
    chk("state",      idx, 32'(bus.O_state),      32'(st));
    chk("match_seen", idx, 32'(bus.O_match_seen), 32'(seen));
    chk("trig_count", idx, 32'(bus.O_trig_count), 32'(cnt));
    chk("armed",      idx, 32'(bus.O_armed),      32'(st == 3'd1));
    chk("busy",       idx, 32'(bus.O_busy),       32'(st == 3'd2 || st == 3'd3 || st == 3'd4));
  endtask

  task automatic drive(input vec_t v);
    bus.I_arm = v.arm; bus.I_abort = v.abort; bus.I_match = v.match;
    bus.I_matching_pattern = v.pat; bus.I_rule_select = v.sel;
    bus.I_match_target = v.target; bus.I_delay = v.dly; bus.I_pulse_width = v.wid;
    bus.I_holdoff = v.hld; bus.I_oneshot = v.oneshot;
  endtask

  initial begin
    logic [7:0] exp_cnt;
    vec_t       v;

    bus.I_arm = 0; bus.I_abort = 0; bus.I_match = 0; bus.I_matching_pattern = '0;
    bus.I_rule_select = '0; bus.I_match_target = '0; bus.I_delay = '0;
    bus.I_pulse_width = '0; bus.I_holdoff = '0; bus.I_oneshot = 0;

    // Single match, immediate 1-cycle one-shot pulse
    c_sel = 8'h01; c_target = 8'd1; c_dly = 0; c_wid = 1; c_hld = 0; c_oneshot = 1;
    add(1, 0, 0, 8'h00, 0, 3'd1, 8'd0, 8'd0);
    add(0, 0, 0, 8'h00, 0, 3'd1, 8'd0, 8'd0);
    add(0, 0, 1, 8'h01, 1, 3'd3, 8'd1, 8'd1);
    add(0, 0, 0, 8'h00, 0, 3'd0, 8'd1, 8'd1);
    add(0, 0, 1, 8'h01, 0, 3'd0, 8'd1, 8'd1);

    // Target 3, delay 5, width 4, holdoff 10, re-arming; match in arm cycle ignored
    c_sel = 8'h01; c_target = 8'd3; c_dly = 5; c_wid = 4; c_hld = 10; c_oneshot = 0;
    add(1, 0, 1, 8'h01, 0, 3'd1, 8'd0, 8'd1);
    add(0, 0, 1, 8'h01, 0, 3'd1, 8'd1, 8'd1);
    add(0, 0, 0, 8'h00, 0, 3'd1, 8'd1, 8'd1);
    add(0, 0, 1, 8'h01, 0, 3'd1, 8'd2, 8'd1);
    add(0, 0, 0, 8'h00, 0, 3'd1, 8'd2, 8'd1);
    add(0, 0, 1, 8'h01, 0, 3'd2, 8'd3, 8'd1);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 8'h01, 0, 3'd2, 8'd3, 8'd1);
    add(0, 0, 1, 8'h01, 1, 3'd3, 8'd3, 8'd2);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 8'h01, 1, 3'd3, 8'd3, 8'd2);
    add(0, 0, 1, 8'h01, 0, 3'd4, 8'd3, 8'd2);
    for (int i = 0; i < 9; i++) add(0, 0, 1, 8'h01, 0, 3'd4, 8'd3, 8'd2);
    add(0, 0, 1, 8'h01, 0, 3'd1, 8'd0, 8'd2);

    // Rule qualification and arm-while-armed
    c_sel = 8'h04; c_target = 8'd2; c_dly = 0; c_wid = 1; c_hld = 0; c_oneshot = 1;
    add(0, 0, 1, 8'h03, 0, 3'd1, 8'd0, 8'd2);
    add(0, 0, 1, 8'h84, 0, 3'd1, 8'd1, 8'd2);
    add(1, 0, 0, 8'h00, 0, 3'd1, 8'd1, 8'd2);
    add(0, 0, 1, 8'h03, 0, 3'd1, 8'd1, 8'd2);
    add(0, 0, 1, 8'h04, 1, 3'd3, 8'd2, 8'd3);
    add(0, 0, 0, 8'h00, 0, 3'd0, 8'd2, 8'd3);

    // Abort with simultaneous arm during DELAY
    c_sel = 8'h01; c_target = 8'd1; c_dly = 3; c_wid = 2; c_hld = 0; c_oneshot = 1;
    add(1, 0, 0, 8'h00, 0, 3'd1, 8'd0, 8'd3);
    add(0, 0, 1, 8'h01, 0, 3'd2, 8'd1, 8'd3);
    add(0, 0, 0, 8'h00, 0, 3'd2, 8'd1, 8'd3);
    add(1, 1, 0, 8'h00, 0, 3'd0, 8'd0, 8'd3);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 8'h00, 0, 3'd0, 8'd0, 8'd3);
    add(1, 1, 0, 8'h00, 0, 3'd0, 8'd0, 8'd3);

    // Zero width/target act as 1; continuous back-to-back pulses every 2 cycles
    c_sel = 8'hFF; c_target = 8'd0; c_dly = 0; c_wid = 0; c_hld = 0; c_oneshot = 0;
    add(1, 0, 1, 8'h01, 0, 3'd1, 8'd0, 8'd3);
    add(0, 0, 1, 8'h10, 1, 3'd3, 8'd1, 8'd4);
    add(0, 0, 1, 8'h10, 0, 3'd1, 8'd0, 8'd4);
    add(0, 0, 1, 8'h10, 1, 3'd3, 8'd1, 8'd5);
    add(0, 0, 1, 8'h10, 0, 3'd1, 8'd0, 8'd5);
    add(0, 0, 1, 8'h10, 1, 3'd3, 8'd1, 8'd6);
    add(0, 0, 1, 8'h10, 0, 3'd1, 8'd0, 8'd6);

    // Reset state
    repeat (2) @(posedge TRACECLK);
    #1;
    check_outputs(0, 1'b0, 3'd0, 8'd0, 8'd0);
    reset = 1'b0;

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge TRACECLK);
      #1;
      check_outputs(i + 1, tbl[i].trig, tbl[i].st, tbl[i].seen, tbl[i].cnt);
    end

    // Continue continuous mode until the trigger counter wraps 255 -> 0
    v = tbl[tbl.size() - 1];
    v.arm = 0;
    drive(v);
    exp_cnt = 8'd6;
    for (int i = 0; i < 250; i++) begin
      exp_cnt = exp_cnt + 8'd1;
      @(posedge TRACECLK);
      #1;
      check_outputs(1000 + 2 * i, 1'b1, 3'd3, 8'd1, exp_cnt);
      @(posedge TRACECLK);
      #1;
      check_outputs(1001 + 2 * i, 1'b0, 3'd1, 8'd0, exp_cnt);
    end
    n_vec++;
    chk("trig_count_wrap", 1500, 32'(bus.O_trig_count), 32'd0);

    // Asynchronous reset asserted between edges in the middle of a long pulse
    v.wid = 16'd5; v.target = 8'd1; v.oneshot = 1'b1;
    drive(v);
    @(posedge TRACECLK);
    #1;
    check_outputs(2000, 1'b1, 3'd3, 8'd1, 8'd1);
    bus.I_match = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_outputs(2001, 1'b0, 3'd0, 8'd0, 8'd0);
    #2;
    reset = 1'b0;
    @(posedge TRACECLK);
    #1;
    check_outputs(2002, 1'b0, 3'd0, 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
